// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the shared 128-bit main-memory line port.
// Port I (instruction cache) and port D (data cache) compete for one
// outstanding block transaction. D is preferred, but a starvation counter
// hands priority to I after STARVE_LIMIT waiting cycles. The response path
// from memory is combinational. After a completed transaction the finished
// port is masked for one cycle, so a cache FSM that drops valid one cycle
// late does not re-issue the same request.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned STAT_W       = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req_valid,
  input  logic              i_req_rw,
  input  logic [31:0]       i_req_addr,
  input  logic [127:0]      i_req_data,
  output logic [127:0]      i_res_data,
  output logic              i_res_ready,
  input  logic              d_req_valid,
  input  logic              d_req_rw,
  input  logic [31:0]       d_req_addr,
  input  logic [127:0]      d_req_data,
  output logic [127:0]      d_res_data,
  output logic              d_res_ready,
  output logic              mem_req_valid,
  output logic              mem_req_rw,
  output logic [31:0]       mem_req_addr,
  output logic [127:0]      mem_req_data,
  input  logic [127:0]      mem_res_data,
  input  logic              mem_res_ready,
  output logic              grant_i,
  output logic              grant_d,
  output logic              busy,
  output logic [STAT_W-1:0] stat_i_grants,
  output logic [STAT_W-1:0] stat_d_grants,
  output logic [STAT_W-1:0] stat_conflicts
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_mask_i;
  logic                r_mask_d;
  logic [3:0]          r_starve_cnt;
  logic [STAT_W-1:0]   r_stat_i;
  logic [STAT_W-1:0]   r_stat_d;
  logic [STAT_W-1:0]   r_stat_conf;

  logic w_i_elig;
  logic w_d_elig;
  logic w_start_i;
  logic w_start_d;
  logic w_conflict;

  assign w_i_elig   = i_req_valid & ~r_mask_i;
  assign w_d_elig   = d_req_valid & ~r_mask_d;
  assign w_start_i  = (r_state == IDLE) && (w_state_nxt == GNT_I);
  assign w_start_d  = (r_state == IDLE) && (w_state_nxt == GNT_D);
  assign w_conflict = (r_state == IDLE) && w_i_elig && w_d_elig;

  // Next-state arbitration and the combinational memory/response muxing.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned, which would infer a latch.
    w_state_nxt   = r_state;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    i_res_data    = '0;
    i_res_ready   = 1'b0;
    d_res_data    = '0;
    d_res_ready   = 1'b0;
    grant_i       = 1'b0;
    grant_d       = 1'b0;
    busy          = 1'b0;
    case (r_state)
      IDLE: begin
        // D wins unless I has waited long enough and is itself eligible.
        if (w_d_elig && !(w_i_elig && (r_starve_cnt == LP_LIMIT)))
          w_state_nxt = GNT_D;
        else if (w_i_elig)
          w_state_nxt = GNT_I;
      end
      GNT_I: begin
        grant_i       = 1'b1;
        busy          = 1'b1;
        mem_req_valid = i_req_valid;
        mem_req_rw    = i_req_rw;
        mem_req_addr  = i_req_addr;
        mem_req_data  = i_req_data;
        i_res_data    = mem_res_data;
        i_res_ready   = mem_res_ready & i_req_valid;
        // Withdrawal wins over a coincident ready: no pulse, no mask.
        if (!i_req_valid || mem_res_ready)
          w_state_nxt = IDLE;
      end
      GNT_D: begin
        grant_d       = 1'b1;
        busy          = 1'b1;
        mem_req_valid = d_req_valid;
        mem_req_rw    = d_req_rw;
        mem_req_addr  = d_req_addr;
        mem_req_data  = d_req_data;
        d_res_data    = mem_res_data;
        d_res_ready   = mem_res_ready & d_req_valid;
        if (!d_req_valid || mem_res_ready)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register plus one-cycle masks for the port that just completed.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    if (reset) begin
      r_state  <= IDLE;
      r_mask_i <= 1'b0;
      r_mask_d <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mask_i <= i_res_ready;
      r_mask_d <= d_res_ready;
    end
  end

  // Starvation counter: counts I waiting behind D, clears on I grant or idle I.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (!i_req_valid || w_start_i) begin
      r_starve_cnt <= '0;
    end else if ((r_state == GNT_D || w_start_d) && (r_starve_cnt < LP_LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Saturating grant and conflict statistics.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stat_i    <= '0;
      r_stat_d    <= '0;
      r_stat_conf <= '0;
    end else begin
      if (w_start_i && (r_stat_i != '1))
        r_stat_i <= r_stat_i + STAT_W'(1);
      if (w_start_d && (r_stat_d != '1))
        r_stat_d <= r_stat_d + STAT_W'(1);
      if (w_conflict && (r_stat_conf != '1))
        r_stat_conf <= r_stat_conf + STAT_W'(1);
    end
  end

  assign stat_i_grants  = r_stat_i;
  assign stat_d_grants  = r_stat_d;
  assign stat_conflicts = r_stat_conf;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the single main-memory line port (128-bit blocks) between the instruction-cache FSM (port I) and the data-cache FSM (port D).
- Sits between both cache controllers and `DMemory`.
- Grants one outstanding block transaction at a time and holds the grant until memory signals ready.
- Prefers port D, with a starvation guard for port I, and exports grant/conflict statistics.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive cycles port I may wait while D is granted before I takes priority (1..15).
- `STAT_W`, default 32: width of each statistics counter.

Ports:
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-high; all state cleared while high.
- `i_req_valid`  in  1: port I request; held high until `i_res_ready`.
- `i_req_rw`  in  1: 1 = block write, 0 = block read.
- `i_req_addr`  in  32: byte address; bits [3:0] ignored by memory.
- `i_req_data`  in  128: write block.
- `i_res_data`  out  128: read block returned to port I.
- `i_res_ready`  out  1: one-cycle completion pulse to port I.
- `d_req_valid`, `d_req_rw`, `d_req_addr`, `d_req_data`, `d_res_data`, `d_res_ready`: same widths and meaning as the port I signals, for port D.
- `mem_req_valid`  out  1: request to memory.
- `mem_req_rw`  out  1: direction to memory.
- `mem_req_addr`  out  32: address to memory.
- `mem_req_data`  out  128: write data to memory.
- `mem_res_data`  in  128: read data from memory.
- `mem_res_ready`  in  1: one-cycle completion from memory; meaningful only while `mem_req_valid` is high.
- `grant_i`, `grant_d`  out  1: current owner, one-hot or both 0.
- `busy`  out  1: a transaction is in flight.
- `stat_i_grants`, `stat_d_grants`, `stat_conflicts`  out  STAT_W: saturating counters.

## Operation
FSM states: IDLE, GNT_I, GNT_D.

IDLE:
- Arbitrates among eligible requests and registers the winner.
- A port is eligible when its valid is high and it is not masked.
- D wins over I, except when `starve_cnt == STARVE_LIMIT`; then I wins.
- If neither port is eligible, the FSM stays in IDLE.

GNT_x:
- Memory request bus = granted port's rw/addr/data, with `mem_req_valid = x_req_valid`.
- `x_res_ready = mem_res_ready & mem_req_valid`.
- `x_res_data = mem_res_data`.
- Non-granted port: `res_ready = 0`, `res_data = 0`.
- When `mem_res_ready` is seen: next state IDLE, and the completed port is masked for exactly the following cycle. This prevents re-issue from a cache FSM that drops valid one cycle late.

Requester withdrawal:
- If the granted port drops valid before ready (abandoned request), the FSM returns to IDLE next cycle without a mask.

`starve_cnt` (4 bits):
- Increments each cycle `i_req_valid` is high while state is GNT_D, or while IDLE grants D.
- Saturates at STARVE_LIMIT.
- Clears on any grant to I or when `i_req_valid` is low.

Statistics:
- `stat_x_grants` increments on each IDLE→GNT_x transition.
- `stat_conflicts` increments on each IDLE cycle where both ports are eligible.
- All counters saturate at all-ones and never wrap.

Reset values:
- State IDLE; all outputs 0; counters 0; masks 0; `starve_cnt` 0.

## Timing
- Grant latency: request eligible in IDLE at cycle t → `grant_x` and `mem_req_valid` high from cycle t+1.
- Response path is combinational: memory ready at cycle r → `x_res_ready` in cycle r. State is IDLE at r+1 (port masked), so the earliest re-grant of the same port is visible at r+3. The other port can be granted at r+2.
- Back-to-back I then D with D waiting: D `mem_req_valid` is visible at r+2, giving one dead cycle between transactions.
- Reset asserted mid-transaction: `mem_req_valid`, grants and ready pulses drop immediately (asynchronously). The in-flight memory operation is abandoned; memory must tolerate valid dropping.
- `mem_res_ready` arriving in IDLE, or while `mem_req_valid` is low, is ignored. No pulse is forwarded to either port.
- Simultaneous `mem_res_ready` and withdrawal of the granted valid: treated as withdrawal. No ready is forwarded and no mask is applied.
- Statistics are registered and update one cycle after the triggering event.

## Test plan
- Single D read of addr 0x40: `d_req_valid` at cycle 1 → `grant_d` and `mem_req_addr=0x40` at cycle 2; memory ready at 5 with data 0xA5…A5 → `d_res_ready` and data at 5; IDLE at 6; `stat_d_grants=1`.
- Simultaneous I and D requests at cycle 1 → D is granted first; `stat_conflicts=1`; I is granted at ready+2; I sees no ready pulse during the D transaction.
- Starvation, STARVE_LIMIT=4: D re-requests continuously with 1-cycle memory latency while I holds valid → I is granted no later than after the D grant during which `starve_cnt` reaches 4, and `starve_cnt` clears on the I grant.
- Late-drop requester: D keeps valid high one cycle after `d_res_ready` → no second D grant in that cycle; `stat_d_grants` increments by exactly 1.
- Reset pulse while in GNT_I with memory pending → all outputs 0 during reset; after release, a new I request is granted normally; counters read 0.
- Saturation, STAT_W=4: 17 D transactions → `stat_d_grants` holds 15 and does not wrap.
